// File: rtl/subband_synth_if.sv
// Frame/gain/status bundle between the analysis bank side and subband_synth.
//   band_in/band_valid  : one 16-band frame (sfix35_En32 each) with its strobe
//   gain_wr_*           : gain table write port (U2.10, 1024 = unity)
//   overrun_clr         : clears the sticky overrun flag
//   filter_out/out_valid: reconstructed sample (sfix14_En12) and its strobe
//   busy/overrun        : frame in progress / frame dropped while busy
// master = frame producer / controller, slave = subband_synth.
interface subband_synth_if;
    localparam int unsigned NUM_BANDS = 16;
    localparam int unsigned IN_W      = 35;
    localparam int unsigned GAIN_W    = 12;
    localparam int unsigned OUT_W     = 14;
    localparam int unsigned ADDR_W    = 4;

    logic [NUM_BANDS*IN_W-1:0] band_in;
    logic                      band_valid;
    logic                      gain_wr_en;
    logic [ADDR_W-1:0]         gain_wr_addr;
    logic [GAIN_W-1:0]         gain_wr_data;
    logic                      overrun_clr;
    logic signed [OUT_W-1:0]   filter_out;
    logic                      out_valid;
    logic                      busy;
    logic                      overrun;

    modport master (
        output band_in, band_valid, gain_wr_en, gain_wr_addr, gain_wr_data, overrun_clr,
        input  filter_out, out_valid, busy, overrun
    );

    modport slave (
        input  band_in, band_valid, gain_wr_en, gain_wr_addr, gain_wr_data, overrun_clr,
        output filter_out, out_valid, busy, overrun
    );
endinterface

// File: rtl/subband_synth.sv
// Synthesis-side combiner: captures a 16-band frame, weights each band by a
// programmable gain, accumulates one band per cycle, then rounds (half-up)
// and saturates the sum to sfix14_En12.
//   clock, reset (async, active-high)
//   clk_enable : gates all state except gain table writes
//   bus        : subband_synth_if slave (frame in, gain writes, result/status out)
module subband_synth (
    input  logic              clock,
    input  logic              reset,
    input  logic              clk_enable,
    subband_synth_if.slave    bus
);
    localparam int unsigned NUM_BANDS = 16;
    localparam int unsigned IN_W      = 35;
    localparam int unsigned GAIN_W    = 12;
    localparam int unsigned OUT_W     = 14;
    localparam int unsigned IDX_W     = 4;
    localparam int unsigned PROD_W    = 48;
    localparam int unsigned ACC_W     = 52;
    localparam int unsigned SHIFT     = 30;

    localparam logic [GAIN_W-1:0]      GAIN_UNITY = GAIN_W'(1024);
    localparam logic [IDX_W-1:0]       LAST_IDX   = IDX_W'(NUM_BANDS - 1);
    localparam logic signed [ACC_W-1:0] ROUND_BIAS = ACC_W'(64'd1 << (SHIFT - 1));
    localparam logic signed [ACC_W-1:0] SAT_MAX    = ACC_W'(64'sd8191);
    localparam logic signed [ACC_W-1:0] SAT_MIN    = ACC_W'(-64'sd8192);

    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

    state_t state_q, state_d;

    logic signed [IN_W-1:0]  snap_q [NUM_BANDS];
    logic [GAIN_W-1:0]       gain_q [NUM_BANDS];
    logic signed [ACC_W-1:0] acc_q;
    logic [IDX_W-1:0]        idx_q;

    logic start_c, accum_c, result_c, overrun_set_c;

    logic signed [GAIN_W:0]   gain_s_c;
    logic signed [PROD_W-1:0] prod_c;
    logic signed [ACC_W-1:0]  rounded_c;
    logic signed [ACC_W-1:0]  shifted_c;
    logic signed [OUT_W-1:0]  sat_c;

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            state_q <= IDLE;
        else if (clk_enable)
            state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.band_valid) state_d = ACCUM;
            ACCUM:   if (idx_q == LAST_IDX) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Per-state control strobes; a frame arriving outside IDLE is dropped
    always_comb begin
        start_c       = 1'b0;
        accum_c       = 1'b0;
        result_c      = 1'b0;
        overrun_set_c = 1'b0;
        case (state_q)
            IDLE:    start_c  = bus.band_valid;
            ACCUM:   accum_c  = 1'b1;
            DONE:    result_c = 1'b1;
            default: ;
        endcase
        if (state_q != IDLE && bus.band_valid)
            overrun_set_c = 1'b1;
    end

    // Gain read at the cycle of use, so same-edge writes see the old value
    always_comb begin
        gain_s_c  = signed'({1'b0, gain_q[idx_q]});
        prod_c    = PROD_W'(snap_q[idx_q]) * PROD_W'(gain_s_c);
        rounded_c = acc_q + ROUND_BIAS;
        shifted_c = rounded_c >>> SHIFT;
        if (shifted_c > SAT_MAX)
            sat_c = OUT_W'(SAT_MAX);
        else if (shifted_c < SAT_MIN)
            sat_c = OUT_W'(SAT_MIN);
        else
            sat_c = OUT_W'(shifted_c);
    end

    // Gain table: writable on any edge regardless of clk_enable
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < NUM_BANDS; k++)
                gain_q[k] <= GAIN_UNITY;
        end else if (bus.gain_wr_en) begin
            gain_q[bus.gain_wr_addr] <= bus.gain_wr_data;
        end
    end

    // Datapath and registered outputs
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < NUM_BANDS; k++)
                snap_q[k] <= '0;
            acc_q          <= '0;
            idx_q          <= '0;
            bus.filter_out <= '0;
            bus.out_valid  <= 1'b0;
            bus.busy       <= 1'b0;
            bus.overrun    <= 1'b0;
        end else if (clk_enable) begin
            bus.out_valid <= result_c;
            bus.busy      <= (state_d != IDLE);
            if (start_c) begin
                for (int k = 0; k < NUM_BANDS; k++)
                    snap_q[k] <= bus.band_in[k*IN_W +: IN_W];
                acc_q <= '0;
                idx_q <= '0;
            end
            if (accum_c) begin
                acc_q <= acc_q + ACC_W'(prod_c);
                idx_q <= idx_q + IDX_W'(1);
            end
            if (result_c)
                bus.filter_out <= sat_c;
            // Set has priority over clear
            if (overrun_set_c)
                bus.overrun <= 1'b1;
            else if (bus.overrun_clr)
                bus.overrun <= 1'b0;
        end
    end
endmodule

// File: tb/tb_subband_synth.sv
// Directed + randomized bench for subband_synth with an expected-value queue.
module tb_subband_synth;
    localparam int NB = 16;
    localparam int IW = 35;

    logic clock = 1'b0;
    logic reset;
    logic clk_enable;

    subband_synth_if bus ();

    subband_synth dut (
        .clock      (clock),
        .reset      (reset),
        .clk_enable (clk_enable),
        .bus        (bus)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;
    int exp_q[$];
    logic [11:0] gain_m [NB];
    logic [NB*IW-1:0] bands;
    longint one_q32 = 64'sd1 << 32;

    task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clear_bands();
        bands = '0;
    endtask

    task automatic set_band(input int k, input longint v);
        bands[k*IW +: IW] = IW'(v);
    endtask

    task automatic write_gain(input int k, input int g);
        @(negedge clock);
        bus.gain_wr_en   = 1'b1;
        bus.gain_wr_addr = 4'(k);
        bus.gain_wr_data = 12'(g);
        gain_m[k]        = 12'(g);
        @(negedge clock);
        bus.gain_wr_en   = 1'b0;
    endtask

    // Drives band_valid for one edge (E0); returns at the negedge after E0
    task automatic start_frame();
        @(negedge clock);
        bus.band_in    = bands;
        bus.band_valid = 1'b1;
        @(negedge clock);
        bus.band_valid = 1'b0;
    endtask

    // Waits for out_valid, counting edges after E0; optional clk_enable gap
    task automatic wait_out(input int lat_exp, input int start_n, input int drop_at, input int drop_len);
        bit seen = 0;
        int exp_v;
        for (int n = start_n + 1; n <= start_n + 80 && !seen; n++) begin
            @(negedge clock);
            if (bus.out_valid) begin
                seen = 1;
                check("latency", 64'(n), 64'(lat_exp));
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $error("FAIL unexpected_out_valid: observed 1 expected 0");
                end else begin
                    exp_v = exp_q.pop_front();
                    check("filter_out", bus.filter_out, 64'(exp_v));
                end
            end
            if (n == drop_at) clk_enable = 1'b0;
            if (n == drop_at + drop_len) clk_enable = 1'b1;
        end
        if (!seen) begin
            checks++;
            errors++;
            $error("FAIL out_valid_timeout: observed 0 expected 1");
        end
    endtask

    function automatic int model();
        longint acc = 0;
        longint b;
        for (int k = 0; k < NB; k++) begin
            b = longint'($signed(bands[k*IW +: IW]));
            acc += b * longint'({1'b0, gain_m[k]});
        end
        acc = (acc + (64'sd1 << 29)) >>> 30;
        if (acc > 8191) acc = 8191;
        if (acc < -8192) acc = -8192;
        return int'(acc);
    endfunction

    initial begin
        int cnt;
        reset            = 1'b1;
        clk_enable       = 1'b1;
        bus.band_in      = '0;
        bus.band_valid   = 1'b0;
        bus.gain_wr_en   = 1'b0;
        bus.gain_wr_addr = '0;
        bus.gain_wr_data = '0;
        bus.overrun_clr  = 1'b0;
        for (int k = 0; k < NB; k++) gain_m[k] = 12'd1024;
        repeat (3) @(negedge clock);
        check("rst_filter_out", bus.filter_out, 0);
        check("rst_out_valid", 64'(bus.out_valid), 0);
        check("rst_busy", 64'(bus.busy), 0);
        check("rst_overrun", 64'(bus.overrun), 0);
        reset = 1'b0;

        // Unity impulse
        clear_bands(); set_band(0, one_q32);
        exp_q.push_back(4096);
        start_frame();
        check("busy_after_e0", 64'(bus.busy), 1);
        wait_out(17, 0, -1, 0);
        check("busy_after_done", 64'(bus.busy), 0);
        @(negedge clock);
        check("out_valid_one_cycle", 64'(bus.out_valid), 0);

        // Gain and sum
        write_gain(3, 512);
        clear_bands(); set_band(3, one_q32); set_band(7, -(64'sd1 << 31));
        exp_q.push_back(0);
        start_frame(); wait_out(17, 0, -1, 0);
        write_gain(7, 0);
        exp_q.push_back(2048);
        start_frame(); wait_out(17, 0, -1, 0);
        write_gain(3, 1024); write_gain(7, 1024);

        // Saturation
        clear_bands();
        for (int k = 0; k < NB; k++) set_band(k, 64'sd1 << 30);
        exp_q.push_back(8191);
        start_frame(); wait_out(17, 0, -1, 0);
        for (int k = 0; k < NB; k++) set_band(k, -(64'sd1 << 30));
        exp_q.push_back(-8192);
        start_frame(); wait_out(17, 0, -1, 0);

        // Rounding
        clear_bands(); set_band(0, 64'sd1 << 19);
        exp_q.push_back(1);
        start_frame(); wait_out(17, 0, -1, 0);
        set_band(0, -(64'sd1 << 19));
        exp_q.push_back(0);
        start_frame(); wait_out(17, 0, -1, 0);
        set_band(0, (64'sd1 << 19) - 1);
        exp_q.push_back(0);
        start_frame(); wait_out(17, 0, -1, 0);

        // Overrun: second strobe 5 edges after the first is dropped
        clear_bands(); set_band(0, one_q32);
        exp_q.push_back(4096);
        start_frame();
        repeat (4) @(negedge clock);
        set_band(0, -one_q32);
        bus.band_in    = bands;
        bus.band_valid = 1'b1;
        @(negedge clock);
        bus.band_valid = 1'b0;
        check("overrun_set", 64'(bus.overrun), 1);
        wait_out(17, 5, -1, 0);
        cnt = 0;
        repeat (30) begin
            @(negedge clock);
            if (bus.out_valid) cnt++;
        end
        check("no_second_out_valid", 64'(cnt), 0);
        check("overrun_sticky", 64'(bus.overrun), 1);
        @(negedge clock); bus.overrun_clr = 1'b1;
        @(negedge clock); bus.overrun_clr = 1'b0;
        check("overrun_cleared", 64'(bus.overrun), 0);

        // clk_enable dropped for 10 cycles during ACCUM
        clear_bands(); set_band(0, one_q32); set_band(5, -(64'sd1 << 30));
        exp_q.push_back(3072);
        start_frame(); wait_out(27, 0, 5, 10);

        // Gain write to a not-yet-consumed band affects the current frame
        clear_bands(); set_band(15, one_q32);
        exp_q.push_back(2048);
        start_frame();
        repeat (3) @(negedge clock);
        bus.gain_wr_en = 1'b1; bus.gain_wr_addr = 4'd15; bus.gain_wr_data = 12'd512;
        gain_m[15] = 12'd512;
        @(negedge clock);
        bus.gain_wr_en = 1'b0;
        wait_out(17, 4, -1, 0);
        write_gain(15, 1024);

        // Randomized gains and bands against the model
        for (int r = 0; r < 3; r++) begin
            for (int k = 0; k < NB; k++) write_gain(k, int'($urandom_range(0, 4095)));
            clear_bands();
            for (int k = 0; k < NB; k++)
                set_band(k, $signed({$urandom, $urandom}) >>> (r + 30));
            exp_q.push_back(model());
            start_frame(); wait_out(17, 0, -1, 0);
        end

        // Reset mid-ACCUM aborts the frame and restores gains
        write_gain(0, 0);
        clear_bands(); set_band(0, one_q32);
        start_frame();
        repeat (5) @(negedge clock);
        reset = 1'b1;
        #1;
        check("midrst_filter_out", bus.filter_out, 0);
        check("midrst_out_valid", 64'(bus.out_valid), 0);
        check("midrst_busy", 64'(bus.busy), 0);
        check("midrst_overrun", 64'(bus.overrun), 0);
        @(negedge clock);
        reset = 1'b0;
        for (int k = 0; k < NB; k++) gain_m[k] = 12'd1024;
        exp_q.push_back(4096);
        start_frame(); wait_out(17, 0, -1, 0);
        check("queue_drained", 64'(exp_q.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
